// File: rtl/freq_det_pkg.sv
// +----------------------------------------------------------------------------+
// | freq_det_pkg : shared types, default widths and saturating abs helper     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package freq_det_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;
  localparam int AVG_DEPTH  = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // |x| clipped to the largest positive value of a w-bit signed number
  function automatic int abs_sat(input int x, input int w);
    int lim;
    lim = (1 << (w - 1)) - 1;
    if (x >= 0)
      return x;
    else if (-x > lim)
      return lim;
    else
      return -x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/freq_det_peak.sv
// +----------------------------------------------------------------------------+
// | freq_det_peak : saturating |sample| and running maximum, reloaded on load  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module freq_det_peak
  import freq_det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_load,
  input  logic              i_acc,
  output logic [DATA_W-1:0] o_peak
);

  logic [DATA_W-1:0] w_abs;
  logic [DATA_W-1:0] r_peak;

  assign w_abs = DATA_W'(abs_sat(int'($signed(i_sample)), DATA_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak <= '0;
    end else if (i_load) begin
      r_peak <= w_abs;
    end else if (i_acc && (w_abs > r_peak)) begin
      r_peak <= w_abs;
    end
  end

  assign o_peak = r_peak;

endmodule

`default_nettype wire

// File: rtl/freq_detector.sv
// +----------------------------------------------------------------------------+
// | freq_detector : period / peak-magnitude meter between rising crossings    |
// | Optional macro FREQ_DET_AVG_EN reports averages over groups of periods.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module freq_detector
  import freq_det_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_signal,
  output logic [CNT_W-1:0]  out_counter,
  output logic              done,
  output logic [DATA_W-1:0] out_magnitude
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_prev;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_rx;
  logic              w_start;
  logic              w_report;
  logic              w_timeout;
  logic [DATA_W-1:0] w_peak;
  logic              r_done;
  logic [CNT_W-1:0]  r_out_cnt;
  logic [DATA_W-1:0] r_out_mag;

  // previous <= 0 and current > 0, both as signed values
  assign w_rx = (r_prev[DATA_W-1] || (r_prev == '0)) &&
                (!in_signal[DATA_W-1] && (in_signal != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_report    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rx) begin
          w_state_nxt = MEASURE;
          w_start     = 1'b1;
        end
      end
      MEASURE: begin
        if (w_rx) begin
          w_report = 1'b1;
          w_start  = 1'b1;
        end else if (r_cnt == C_CNT_MAX) begin
          w_report    = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= in_signal;
      if (w_start)
        r_cnt <= CNT_W'(1);
      else if (w_timeout)
        r_cnt <= '0;
      else if (r_state == MEASURE)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  freq_det_peak #(
    .DATA_W (DATA_W)
  ) u_peak (
    .clk      (clk),
    .rst      (rst),
    .i_sample (in_signal),
    .i_load   (w_start),
    .i_acc    (r_state == MEASURE),
    .o_peak   (w_peak)
  );

`ifdef FREQ_DET_AVG_EN
  localparam int GRP_W     = $clog2(AVG_DEPTH);
  localparam int AVG_SHIFT = $clog2(AVG_DEPTH);

  logic [CNT_W+1:0]  r_sum;
  logic [GRP_W-1:0]  r_grp;
  logic [DATA_W-1:0] r_gmax;
  logic [CNT_W+1:0]  w_sum_nxt;
  logic [DATA_W-1:0] w_gmax_nxt;

  assign w_sum_nxt  = r_sum + {2'b00, r_cnt};
  assign w_gmax_nxt = (w_peak > r_gmax) ? w_peak : r_gmax;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done    <= 1'b0;
      r_out_cnt <= '0;
      r_out_mag <= '0;
      r_sum     <= '0;
      r_grp     <= '0;
      r_gmax    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_timeout) begin
        r_done    <= 1'b1;
        r_out_cnt <= r_cnt;
        r_out_mag <= w_peak;
        r_sum     <= '0;
        r_grp     <= '0;
        r_gmax    <= '0;
      end else if (w_report) begin
        if (r_grp == GRP_W'(AVG_DEPTH - 1)) begin
          r_done    <= 1'b1;
          r_out_cnt <= CNT_W'(w_sum_nxt >> AVG_SHIFT);
          r_out_mag <= w_gmax_nxt;
          r_sum     <= '0;
          r_grp     <= '0;
          r_gmax    <= '0;
        end else begin
          r_sum  <= w_sum_nxt;
          r_grp  <= r_grp + GRP_W'(1);
          r_gmax <= w_gmax_nxt;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done    <= 1'b0;
      r_out_cnt <= '0;
      r_out_mag <= '0;
    end else begin
      r_done <= w_report;
      if (w_report) begin
        r_out_cnt <= r_cnt;
        r_out_mag <= w_peak;
      end
    end
  end
`endif

  assign done          = r_done;
  assign out_counter   = r_out_cnt;
  assign out_magnitude = r_out_mag;

endmodule

`default_nettype wire

// File: tb/tb_freq_detector.sv
// +----------------------------------------------------------------------------+
// | tb_freq_detector : randomized scoreboard bench for freq_detector          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_freq_detector;

  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;
  localparam int LIM  = (1 << (DW - 1)) - 1;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_signal;
  logic [CW-1:0] out_counter;
  logic          done;
  logic [DW-1:0] out_magnitude;

  int checks;
  int errors;
  int cyc;

  typedef struct {
    int eidx;
    int cnt;
    int mag;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // reference model state: measurement window described by its start edge
  int m_prev;
  bit m_meas;
  int m_last;
  int abs_q[$];

  freq_detector #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_signal     (in_signal),
    .out_counter   (out_counter),
    .done          (done),
    .out_magnitude (out_magnitude)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat_abs(input int s);
    if (s >= 0) return s;
    if (-s > LIM) return LIM;
    return -s;
  endfunction

  function void model_reset();
    m_prev = 0;
    m_meas = 0;
    m_last = 0;
    abs_q.delete();
  endfunction

  function void model_step(input int s, input int eidx);
    bit   rx;
    int   el;
    int   pk;
    exp_t x;
    rx = (m_prev <= 0) && (s > 0);
    if (m_meas) begin
      el = eidx - m_last;
      pk = 0;
      foreach (abs_q[i]) if (abs_q[i] > pk) pk = abs_q[i];
      if (rx) begin
        x.eidx = eidx; x.cnt = el; x.mag = pk;
        sb.push_back(x);
      end else if (el == MAXC) begin
        x.eidx = eidx; x.cnt = MAXC; x.mag = pk;
        sb.push_back(x);
        m_meas = 0;
      end
    end
    if (rx) begin
      m_meas = 1;
      m_last = eidx;
      abs_q.delete();
      abs_q.push_back(sat_abs(s));
    end else if (m_meas) begin
      abs_q.push_back(sat_abs(s));
    end
    m_prev = s;
  endfunction

  // called at a falling edge; returns at the next falling edge
  task automatic drive(input int s);
    in_signal = 8'(s);
    model_step(s, cyc + 1);
    @(negedge clk);
  endtask

  task automatic square(input int hi, input int lo, input int nhi, input int nlo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < nhi; k++) drive(hi);
      for (int k = 0; k < nlo; k++) drive(lo);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (out_counter !== '0 || out_magnitude !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got cnt=%0d mag=%0d done=%0b, want 0/0/0",
               tag, out_counter, out_magnitude, done);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_zero("async_reset");
    @(posedge clk);
    #1 check_zero("held_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].eidx < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_done: no done for edge %0d (cnt=%0d mag=%0d), now edge %0d",
                 sb[0].eidx, sb[0].cnt, sb[0].mag, cyc);
        void'(sb.pop_front());
      end
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: edge %0d cnt=%0d mag=%0d, none expected",
                   cyc, out_counter, out_magnitude);
        end else begin
          e = sb.pop_front();
          if (e.eidx != cyc || int'(out_counter) != e.cnt || int'(out_magnitude) != e.mag) begin
            errors++;
            $display("FAIL done_result: got edge=%0d cnt=%0d mag=%0d, want edge=%0d cnt=%0d mag=%0d",
                     cyc, out_counter, out_magnitude, e.eidx, e.cnt, e.mag);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst       = 1'b1;
    in_signal = '0;
    model_reset();
    #1 check_zero("reset_state");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    square(64, -64, 100, 100, 3);
    square(64, -64, 50, 0, 1);
    do_reset();
    square(64, -64, 100, 100, 2);

    square(15, 0, 19, 18, 4);
    square(127, -128, 1, 1, 10);

    drive(-5);
    for (int k = 0; k < 300; k++) drive(20);
    square(20, -5, 30, 30, 3);

    for (int seg = 0; seg < 10; seg++) begin
      case ($urandom_range(0, 2))
        0: square($urandom_range(1, 127), -int'($urandom_range(0, 128)),
                  $urandom_range(1, 60), $urandom_range(1, 60), $urandom_range(2, 4));
        1: for (int k = 0; k < 40; k++) drive(int'($urandom_range(0, 255)) - 128);
        default: begin
          drive(0);
          for (int k = 0; k < 260; k++) drive($urandom_range(1, 127));
        end
      endcase
    end

    repeat (3) drive(0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected done pulses never seen, want 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
